mem_line_adapter: RTL and testbench
===================================

# mem_line_adapter

Downstream neighbour of the direct-mapped cache controller: converts one 128-bit line request (allocate read or write-back write) into a burst of four 32-bit word transfers on a simple request/grant/rvalid memory port. Reads are reassembled into a full line; write-backs are split into words. Exactly one line operation is in flight at a time; within it, up to four word requests may be outstanding.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- WORD_W, 32, memory word width
- LINE_W, 128, cache line width; BEATS = LINE_W/WORD_W = 4

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- i_line_read  in  1  cache requests line fill; held until o_line_ready
- i_line_write  in  1  cache requests line write-back; held until o_line_ready
- i_line_addr  in  ADDR_W  line address; bits [3:0] ignored
- i_line_writedata  in  LINE_W  line to write back; word i = bits [32i+31:32i]
- o_line_readdata  out  LINE_W  assembled fill line, valid while o_line_ready=1
- o_line_ready  out  1  one-cycle completion pulse
- o_ram_req  out  1  word request valid
- o_ram_we  out  1  1 = write, 0 = read
- o_ram_addr  out  ADDR_W  word byte address
- o_ram_wdata  out  WORD_W  write word
- i_ram_gnt  in  1  request accepted this cycle when o_ram_req=1
- i_ram_rvalid  in  1  read word returned, in request order, ≥1 cycle after grant
- i_ram_rdata  in  WORD_W  returned word

## Operation
- States: IDLE, WR_BURST, RD_BURST, DONE.
- IDLE: i_line_write=1 -> latch base = {i_line_addr[31:4],4'b0} and writedata, go WR_BURST. Else i_line_read=1 -> latch base, go RD_BURST. Both high: write wins (write-back precedes allocate).
- Issue counter iss (0..4): o_ram_req=1 while in a burst and iss<4; o_ram_addr = base + 4*iss; o_ram_wdata = latched word iss; iss increments on req&gnt. Address/data stay stable until granted.
- WR_BURST: when the 4th grant occurs, go DONE (writes are posted).
- RD_BURST: return counter ret (0..4); on i_ram_rvalid, word ret of the line buffer = i_ram_rdata, ret increments; on the 4th rvalid go DONE.
- DONE: o_line_ready=1 for one cycle, o_line_readdata = line buffer; next state IDLE.
- The requester deasserts its request in the cycle after o_line_ready; the request is sampled again only in IDLE.
- i_ram_rvalid outside RD_BURST, or with ret=4, is ignored.
- i_line_* inputs change only in IDLE; they are latched and not re-read mid-burst.
- Address arithmetic: ADDR_W-bit add, wraps modulo 2^ADDR_W (base 0xFFFF_FFF0 -> words 0x...F0, F4, F8, FC).

## Timing
- Reset (reset=0, async): state IDLE, iss=ret=0, o_ram_req=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_line_ready=0, o_line_readdata=0.
- Reset mid-burst: partial line discarded, no o_line_ready, stray rvalids after reset release are ignored.
- No combinational path from i_ram_gnt/i_ram_rvalid to o_ram_req or o_line_ready; request outputs derive from registered state/counters.
- Write latency, gnt held 1: request sampled at edge E0; beats on the 4 cycles after E0; o_line_ready in cycle 5 (BEATS+1).
- Read latency, gnt held 1, rvalid L cycles after grant: o_line_ready in cycle BEATS+L+1.
- A grant stall of k cycles delays completion by exactly k cycles.
- Back-to-back: next request sampled in the IDLE cycle after DONE; min 1 idle cycle between bursts.

## Structure
- Package mem_line_pkg: state enum (IDLE, WR_BURST, RD_BURST, DONE), WORD_BYTES=4, BEATS=4, LINE_OFFSET_BITS=4.
- Sub-module mem_line_assembler: word-indexed 128-bit line buffer with write-enable and 2-bit index, shared for read fill; the FSM and counters stay in mem_line_adapter.

## Test plan
- Read, gnt=1, L=1, addr 0x0000_1234: words requested at 0x1230/34/38/3C; rdata 0xA0,0xA1,0xA2,0xA3 -> readdata 0x000000A3_000000A2_000000A1_000000A0, ready in cycle 6.
- Write, gnt=1, addr 0x0000_0040, line 0x44444444_33333333_22222222_11111111 -> we=1 beats 0x40:0x11111111 ... 0x4C:0x44444444, ready in cycle 5.
- Grant stall: gnt low for 3 cycles on beat 2 of a write -> addr/wdata held, ready in cycle 8.
- Read and write asserted together, addr 0x100 -> write burst first, ready pulse, then read sampled after requester re-raises read only.
- Reset asserted after 2 read beats -> all outputs 0 immediately; two late rvalids ignored; next read completes correctly.
- Wrap: read at 0xFFFF_FFF8 -> addresses 0xFFFF_FFF0/F4/F8/FC; rvalid in IDLE produces no ready pulse.

Source files
------------

// File: rtl/mem_line_pkg.sv
// mem_line_pkg: shared state encoding and burst geometry for the line adapter
package mem_line_pkg;
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_t;
    localparam int WORD_BYTES = 4;
    localparam int BEATS = 4;
    localparam int LINE_OFFSET_BITS = 4;
endpackage

// File: rtl/mem_line_assembler.sv
// mem_line_assembler: word-indexed line buffer filled one word at a time
// Ports: clk/reset (async active-low), we + idx select the word written with wdata,
// line is the whole buffer.
module mem_line_assembler #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            line <= '0;
        else if (we)
            line[idx*WORD_W +: WORD_W] <= wdata;
    end
endmodule

// File: rtl/mem_line_adapter.sv
// mem_line_adapter: splits one cache line operation into four word transfers
// Ports: clk/reset (async active-low); i_line_* is the cache-side request, held
// until the one-cycle o_line_ready pulse; o_ram_*/i_ram_* is the req/gnt/rvalid
// word port, with read words returned in request order.
module mem_line_adapter
    import mem_line_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_line_read,
    input  logic              i_line_write,
    input  logic [ADDR_W-1:0] i_line_addr,
    input  logic [LINE_W-1:0] i_line_writedata,
    output logic [LINE_W-1:0] o_line_readdata,
    output logic              o_line_ready,
    output logic              o_ram_req,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [WORD_W-1:0] o_ram_wdata,
    input  logic              i_ram_gnt,
    input  logic              i_ram_rvalid,
    input  logic [WORD_W-1:0] i_ram_rdata
);
    state_t            state, next;
    logic [2:0]        iss, ret;
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] wline;
    logic              burst, grant, fill;
    logic              unused_offset;

    assign unused_offset = ^i_line_addr[LINE_OFFSET_BITS-1:0];

    // Request outputs come only from state and counters, never from gnt/rvalid.
    assign burst        = state == WR_BURST || state == RD_BURST;
    assign o_ram_req    = burst && iss != 3'(BEATS);
    assign o_ram_we     = state == WR_BURST;
    assign o_ram_addr   = base + ADDR_W'(iss) * ADDR_W'(WORD_BYTES);
    assign o_ram_wdata  = wline[iss[1:0]*WORD_W +: WORD_W];
    assign o_line_ready = state == DONE;
    assign grant        = o_ram_req && i_ram_gnt;
    // Returned words beyond the fourth, or outside a read burst, are dropped.
    assign fill         = state == RD_BURST && i_ram_rvalid && ret != 3'(BEATS);

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = i_line_write ? WR_BURST : i_line_read ? RD_BURST : IDLE;
            WR_BURST: next = grant && iss == 3'(BEATS-1) ? DONE : WR_BURST;
            RD_BURST: next = fill && ret == 3'(BEATS-1) ? DONE : RD_BURST;
            DONE:     next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            iss   <= '0;
            ret   <= '0;
            base  <= '0;
            wline <= '0;
        end else begin
            state <= next;
            if (state == IDLE) begin
                iss <= '0;
                ret <= '0;
                if (i_line_write || i_line_read)
                    base <= {i_line_addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                if (i_line_write)
                    wline <= i_line_writedata;
            end else begin
                if (grant)
                    iss <= iss + 3'd1;
                if (fill)
                    ret <= ret + 3'd1;
            end
        end
    end

    mem_line_assembler #(.WORD_W(WORD_W), .LINE_W(LINE_W)) u_asm (
        .clk   (clk),
        .reset (reset),
        .we    (fill),
        .idx   (ret[1:0]),
        .wdata (i_ram_rdata),
        .line  (o_line_readdata)
    );
endmodule

// File: tb/tb_mem_line_adapter.sv
// tb_mem_line_adapter: directed scenario checks for the line adapter
module tb_mem_line_adapter;
    logic         clk = 0;
    logic         reset = 0;
    logic         i_line_read = 0;
    logic         i_line_write = 0;
    logic [31:0]  i_line_addr = 0;
    logic [127:0] i_line_writedata = 0;
    logic [127:0] o_line_readdata;
    logic         o_line_ready, o_ram_req, o_ram_we;
    logic [31:0]  o_ram_addr, o_ram_wdata;
    logic         i_ram_gnt = 1;
    logic         i_ram_rvalid;
    logic [31:0]  i_ram_rdata;

    logic         auto_rv = 0, man_rv = 0, rv_due = 0, rv_en = 1;
    logic [31:0]  auto_rd = 0, man_rd = 0, rv_dat = 0, rd_base = 0;
    logic [31:0]  log_addr [256];
    logic [31:0]  log_wd [256];
    logic         log_we [256];
    int           nlog = 0;
    int           total = 0, bad = 0;
    int           cyc, s;
    logic [127:0] rdl;

    assign i_ram_rvalid = auto_rv | man_rv;
    assign i_ram_rdata  = man_rv ? man_rd : auto_rd;

    always #5 clk = ~clk;

    mem_line_adapter dut (
        .clk(clk), .reset(reset),
        .i_line_read(i_line_read), .i_line_write(i_line_write),
        .i_line_addr(i_line_addr), .i_line_writedata(i_line_writedata),
        .o_line_readdata(o_line_readdata), .o_line_ready(o_line_ready),
        .o_ram_req(o_ram_req), .o_ram_we(o_ram_we),
        .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .i_ram_gnt(i_ram_gnt), .i_ram_rvalid(i_ram_rvalid), .i_ram_rdata(i_ram_rdata)
    );

    // Beat log and memory model: each read grant returns rd_base + word index one cycle later.
    always @(negedge clk) begin
        if (o_ram_req && i_ram_gnt) begin
            if (nlog < 256) begin
                log_addr[nlog] = o_ram_addr;
                log_wd[nlog]   = o_ram_wdata;
                log_we[nlog]   = o_ram_we;
            end
            nlog++;
        end
        rv_due = o_ram_req && i_ram_gnt && !o_ram_we;
        rv_dat = rd_base + {30'b0, o_ram_addr[3:2]};
    end

    always @(posedge clk) begin
        #1;
        auto_rv = rv_due && rv_en;
        auto_rd = rv_dat;
    end

    task automatic launch(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] wd);
        @(posedge clk); #1;
        i_line_read = rd;
        i_line_write = wr;
        i_line_addr = a;
        i_line_writedata = wd;
    endtask

    task automatic wait_ready(output int c_out, output logic [127:0] line);
        c_out = 0;
        line = '0;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (o_line_ready) begin
                c_out = c;
                line = o_line_readdata;
                break;
            end
        end
        @(posedge clk); #1;
        i_line_read = 0;
        i_line_write = 0;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata, o_line_ready, o_line_readdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h rdy=%b rd=%h want all zero",
                     o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata, o_line_ready, o_line_readdata);
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_read;
        s = nlog;
        rd_base = 32'hA0;
        launch(1, 0, 32'h0000_1234, '0);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 6) begin bad++; $display("FAIL read_latency: got %0d want 6", cyc); end
        total++;
        if (rdl !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            bad++; $display("FAIL read_data: got %h want 000000a3000000a2000000a1000000a0", rdl);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_we[s+i], log_addr[s+i]} !== {1'b0, 32'h1230 + 32'(4*i)}) begin
                bad++; $display("FAIL read_beat%0d: got we=%b addr=%h want we=0 addr=%h",
                                i, log_we[s+i], log_addr[s+i], 32'h1230 + 32'(4*i));
            end
        end
        @(negedge clk);
        total++;
        if (o_line_ready !== 1'b0) begin bad++; $display("FAIL read_pulse: got ready=%b want 0", o_line_ready); end
    endtask

    task automatic test_write;
        s = nlog;
        launch(0, 1, 32'h0000_0040, 128'h44444444_33333333_22222222_11111111);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 5) begin bad++; $display("FAIL write_latency: got %0d want 5", cyc); end
        total++;
        if (nlog - s !== 4) begin bad++; $display("FAIL write_beats: got %0d want 4", nlog - s); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_we[s+i], log_addr[s+i], log_wd[s+i]} !== {1'b1, 32'h40 + 32'(4*i), 32'(32'h11111111 * (i+1))}) begin
                bad++; $display("FAIL write_beat%0d: got we=%b addr=%h wd=%h want we=1 addr=%h wd=%h",
                                i, log_we[s+i], log_addr[s+i], log_wd[s+i],
                                32'h40 + 32'(4*i), 32'(32'h11111111 * (i+1)));
            end
        end
        @(negedge clk);
        total++;
        if (o_line_ready !== 1'b0) begin bad++; $display("FAIL write_pulse: got ready=%b want 0", o_line_ready); end
    endtask

    task automatic test_grant_stall;
        launch(0, 1, 32'h0000_0200, 128'hDDDD3333_CCCC2222_BBBB1111_AAAA0000);
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            i_ram_gnt = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                total++;
                if ({o_ram_req, o_ram_addr, o_ram_wdata} !== {1'b1, 32'h204, 32'hBBBB1111}) begin
                    bad++; $display("FAIL stall_hold_c%0d: got req=%b addr=%h wd=%h want req=1 addr=00000204 wd=bbbb1111",
                                    c, o_ram_req, o_ram_addr, o_ram_wdata);
                end
            end
            total++;
            if (o_line_ready !== (c == 8)) begin
                bad++; $display("FAIL stall_ready_c%0d: got %b want %b", c, o_line_ready, c == 8);
            end
        end
        @(posedge clk); #1;
        i_line_write = 0;
        i_ram_gnt = 1;
    endtask

    task automatic test_back_to_back;
        s = nlog;
        rd_base = 32'h50;
        launch(1, 1, 32'h0000_0100, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 5) begin bad++; $display("FAIL both_write_latency: got %0d want 5", cyc); end
        total++;
        if ({log_we[s], log_we[s+3], log_addr[s+3], log_wd[s+3]} !== {2'b11, 32'h10C, 32'h0D0D0D0D}) begin
            bad++; $display("FAIL both_write_first: got we=%b%b addr=%h wd=%h want we=11 addr=0000010c wd=0d0d0d0d",
                            log_we[s], log_we[s+3], log_addr[s+3], log_wd[s+3]);
        end
        s = nlog;
        launch(1, 0, 32'h0000_0100, '0);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 6) begin bad++; $display("FAIL b2b_read_latency: got %0d want 6", cyc); end
        total++;
        if (rdl !== 128'h00000053_00000052_00000051_00000050) begin
            bad++; $display("FAIL b2b_read_data: got %h want 00000053000000520000005100000050", rdl);
        end
        total++;
        if ({log_we[s], log_addr[s]} !== {1'b0, 32'h100}) begin
            bad++; $display("FAIL b2b_read_beat0: got we=%b addr=%h want we=0 addr=00000100", log_we[s], log_addr[s]);
        end
    endtask

    task automatic test_reset_mid_burst;
        rd_base = 32'hB0;
        launch(1, 0, 32'h0000_2000, '0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        reset = 0;
        rv_en = 0;
        i_line_read = 0;
        #1;
        total++;
        if ({o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata, o_line_ready, o_line_readdata} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got req=%b we=%b addr=%h wd=%h rdy=%b rd=%h want all zero",
                     o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata, o_line_ready, o_line_readdata);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            man_rv = (i < 2);
            man_rd = 32'hDEAD_0000 + 32'(i);
            @(negedge clk);
            total++;
            if ({o_line_ready, o_ram_req} !== 2'b00) begin
                bad++; $display("FAIL stray_rvalid%0d: got ready=%b req=%b want 0 0", i, o_line_ready, o_ram_req);
            end
        end
        rv_en = 1;
        rd_base = 32'hC0;
        launch(1, 0, 32'h0000_3000, '0);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 6) begin bad++; $display("FAIL post_reset_latency: got %0d want 6", cyc); end
        total++;
        if (rdl !== 128'h000000C3_000000C2_000000C1_000000C0) begin
            bad++; $display("FAIL post_reset_data: got %h want 000000c3000000c2000000c1000000c0", rdl);
        end
    endtask

    task automatic test_wrap;
        s = nlog;
        rd_base = 32'h10;
        launch(1, 0, 32'hFFFF_FFF8, '0);
        wait_ready(cyc, rdl);
        total++;
        if (cyc !== 6) begin bad++; $display("FAIL wrap_latency: got %0d want 6", cyc); end
        total++;
        if (rdl !== 128'h00000013_00000012_00000011_00000010) begin
            bad++; $display("FAIL wrap_data: got %h want 00000013000000120000001100000010", rdl);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_addr[s+i] !== 32'hFFFF_FFF0 + 32'(4*i)) begin
                bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, log_addr[s+i], 32'hFFFF_FFF0 + 32'(4*i));
            end
        end
        @(posedge clk); #1;
        man_rv = 1;
        man_rd = 32'h99;
        @(negedge clk);
        total++;
        if (o_line_ready !== 1'b0) begin bad++; $display("FAIL idle_rvalid_a: got ready=%b want 0", o_line_ready); end
        @(posedge clk); #1;
        man_rv = 0;
        @(negedge clk);
        total++;
        if ({o_line_ready, o_ram_req} !== 2'b00) begin
            bad++; $display("FAIL idle_rvalid_b: got ready=%b req=%b want 0 0", o_line_ready, o_ram_req);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_grant_stall;
        test_back_to_back;
        test_reset_mid_burst;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
